// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line levels, vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Line levels of the framing bits, common to uart_tx and uart_rx.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // 2-of-3 majority vote used on the mid-bit samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int ECW        = $clog2(OVERSAMPLE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           count_en_i,    // frame in progress (or starting this cycle)
  input  logic           rx_i,
  output logic [ECW-1:0] edge_cnt_o,
  output logic           sampled_bit_o, // valid from edge_cnt = OVERSAMPLE/2+2
  output logic           bit_end_o      // last clock of the current bit
);

  localparam logic [ECW-1:0] LAST  = ECW'(OVERSAMPLE - 1);
  localparam logic [ECW-1:0] SMP_0 = ECW'(OVERSAMPLE / 2 - 1);
  localparam logic [ECW-1:0] SMP_1 = ECW'(OVERSAMPLE / 2);
  localparam logic [ECW-1:0] SMP_2 = ECW'(OVERSAMPLE / 2 + 1);

  logic [ECW-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]     samp_q, samp_d;

  // Next-state for the edge counter and the three mid-bit sample slots.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    samp_d     = samp_q;
    if (!count_en_i) begin
      edge_cnt_d = '0;
    end else if (edge_cnt_q == LAST) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + ECW'(1);
    end
    if (edge_cnt_q == SMP_0) samp_d[0] = rx_i;
    if (edge_cnt_q == SMP_1) samp_d[1] = rx_i;
    if (edge_cnt_q == SMP_2) samp_d[2] = rx_i;
  end

  // Counter and sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
      samp_q     <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

  assign edge_cnt_o    = edge_cnt_q;
  assign sampled_bit_o = majority3(samp_q[0], samp_q[1], samp_q[2]);
  assign bit_end_o     = (edge_cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, data shift register, parity check, result pulses.
// Output protocol: Data_Valid / Par_Err / Stop_Err are single-cycle pulses with
// no backpressure; P_DATA changes only in the cycle Data_Valid is high and
// holds until the next good frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RX_IN,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          Data_Valid,
  output logic                          Par_Err,
  output logic                          Stop_Err,
  output rx_state_e                     dbg_state_o,
  output logic [$clog2(OVERSAMPLE)-1:0] dbg_edge_cnt_o
);

  localparam int ECW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_fail_q, par_fail_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic           count_en;
  logic [ECW-1:0] edge_cnt;
  logic           sampled_bit;
  logic           bit_end;

  // The counter starts in the very IDLE cycle that sees the start edge, so
  // that cycle is edge_cnt 0 of the start bit.
  assign count_en = (state_q != ST_IDLE) || (RX_IN == START_BIT);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .ECW        (ECW)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .count_en_i    (count_en),
    .rx_i          (RX_IN),
    .edge_cnt_o    (edge_cnt),
    .sampled_bit_o (sampled_bit),
    .bit_end_o     (bit_end)
  );

  // Frame FSM next-state, datapath updates and result pulses.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RX_IN == START_BIT) begin
          state_d    = ST_START;
          bit_cnt_d  = '0;
          par_fail_d = 1'b0;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end
      ST_START: begin
        if (bit_end) begin
          // A start bit that votes high was a glitch: drop it silently.
          state_d = (sampled_bit == START_BIT) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_fail_d = (sampled_bit != ((^shift_q) ^ par_typ_q));
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          if (sampled_bit != STOP_BIT) begin
            se_d = 1'b1;
          end else if (par_fail_q) begin
            pe_d = 1'b1;
          end else begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail_q <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_fail_q <= par_fail_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA         = p_data_q;
  assign Data_Valid     = dv_q;
  assign Par_Err        = pe_q;
  assign Stop_Err       = se_q;
  assign dbg_state_o    = state_q;
  assign dbg_edge_cnt_o = edge_cnt;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (DATA_WIDTH=8, OVERSAMPLE=8).
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stop_Err;
  rx_state_e  dbg_state;
  logic [2:0] dbg_edge;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Pulse log, filled at the falling edge: cycle index and P_DATA at the pulse.
  int         dv_t_q[$];
  logic [7:0] dv_d_q[$];
  int         pe_t_q[$];
  int         se_t_q[$];

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .RX_IN          (RX_IN),
    .PAR_EN         (PAR_EN),
    .PAR_TYP        (PAR_TYP),
    .P_DATA         (P_DATA),
    .Data_Valid     (Data_Valid),
    .Par_Err        (Par_Err),
    .Stop_Err       (Stop_Err),
    .dbg_state_o    (dbg_state),
    .dbg_edge_cnt_o (dbg_edge)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Data_Valid) begin
      dv_t_q.push_back(cyc);
      dv_d_q.push_back(P_DATA);
    end
    if (Par_Err)  pe_t_q.push_back(cyc);
    if (Stop_Err) se_t_q.push_back(cyc);
  end

  task automatic clear_log();
    dv_t_q.delete();
    dv_d_q.delete();
    pe_t_q.delete();
    se_t_q.delete();
  endtask

  // Drive one bit for 8 clocks; optional 1-clock inversion at edge_cnt 4.
  task automatic drive_bit(input logic b, input logic glitch);
    RX_IN = b;
    if (glitch) begin
      repeat (4) @(posedge clk);
      #1 RX_IN = ~b;
      @(posedge clk);
      #1 RX_IN = b;
      repeat (3) @(posedge clk);
      #1;
    end else begin
      repeat (8) @(posedge clk);
      #1;
    end
  endtask

  // Whole frame; c0 is the cycle index of t=0. Called 1 time unit after a posedge.
  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                            input logic stop_bit, input logic glitch, input logic flip_cfg,
                            output int c0);
    c0 = cyc;
    drive_bit(1'b0, 1'b0);
    if (flip_cfg) begin
      PAR_EN  = ~PAR_EN;
      PAR_TYP = ~PAR_TYP;
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
    if (has_par) drive_bit(par_bit, 1'b0);
    drive_bit(stop_bit, 1'b0);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL reset_pdata: got %h expected 00", P_DATA); end
    n_vec++; if ({Data_Valid, Par_Err, Stop_Err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {Data_Valid, Par_Err, Stop_Err}); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    n_vec++; if (dbg_edge !== 3'd0) begin n_err++; $display("FAIL reset_edge: got %0d expected 0", dbg_edge); end
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_no_parity();
    int c0;
    PAR_EN = 1'b0;
    clear_log();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c0);
    idle(4);
    n_vec++; if (dv_t_q.size() !== 1) begin n_err++; $display("FAIL nopar_dv_count: got %0d expected 1", dv_t_q.size()); end
    else begin
      n_vec++; if (dv_t_q[0] - c0 !== 80) begin n_err++; $display("FAIL nopar_dv_time: got %0d expected 80", dv_t_q[0] - c0); end
      n_vec++; if (dv_d_q[0] !== 8'hA5) begin n_err++; $display("FAIL nopar_pulse_data: got %h expected a5", dv_d_q[0]); end
    end
    n_vec++; if (pe_t_q.size() + se_t_q.size() !== 0) begin n_err++; $display("FAIL nopar_err_flags: got %0d expected 0", pe_t_q.size() + se_t_q.size()); end
    n_vec++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL nopar_pdata_hold: got %h expected a5", P_DATA); end
  endtask

  task automatic test_parity_even();
    int c0;
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clear_log();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, c0);
    idle(4);
    n_vec++; if (dv_t_q.size() !== 1) begin n_err++; $display("FAIL even_ok_dv_count: got %0d expected 1", dv_t_q.size()); end
    else begin
      n_vec++; if (dv_t_q[0] - c0 !== 88) begin n_err++; $display("FAIL even_ok_dv_time: got %0d expected 88", dv_t_q[0] - c0); end
    end
    n_vec++; if (pe_t_q.size() !== 0) begin n_err++; $display("FAIL even_ok_par_err: got %0d expected 0", pe_t_q.size()); end
    clear_log();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, c0);
    idle(4);
    n_vec++; if (pe_t_q.size() !== 1) begin n_err++; $display("FAIL even_bad_pe_count: got %0d expected 1", pe_t_q.size()); end
    else begin
      n_vec++; if (pe_t_q[0] - c0 !== 88) begin n_err++; $display("FAIL even_bad_pe_time: got %0d expected 88", pe_t_q[0] - c0); end
    end
    n_vec++; if (dv_t_q.size() + se_t_q.size() !== 0) begin n_err++; $display("FAIL even_bad_other: got %0d expected 0", dv_t_q.size() + se_t_q.size()); end
    n_vec++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL even_bad_pdata: got %h expected a5", P_DATA); end
  endtask

  // Odd parity; the config inputs are flipped after the start bit and must be ignored.
  task automatic test_parity_odd_cfg_hold();
    int c0;
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    clear_log();
    send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, c0);
    idle(4);
    n_vec++; if (dv_t_q.size() !== 1) begin n_err++; $display("FAIL odd_dv_count: got %0d expected 1", dv_t_q.size()); end
    else begin
      n_vec++; if (dv_t_q[0] - c0 !== 88) begin n_err++; $display("FAIL odd_dv_time: got %0d expected 88", dv_t_q[0] - c0); end
    end
    n_vec++; if (pe_t_q.size() + se_t_q.size() !== 0) begin n_err++; $display("FAIL odd_err_flags: got %0d expected 0", pe_t_q.size() + se_t_q.size()); end
    n_vec++; if (P_DATA !== 8'h37) begin n_err++; $display("FAIL odd_pdata: got %h expected 37", P_DATA); end
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    idle(2);
  endtask

  task automatic test_start_glitch();
    int c0;
    clear_log();
    c0 = cyc;
    RX_IN = 1'b0;
    repeat (3) @(posedge clk);
    #1 RX_IN = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (dbg_state !== ST_START) begin n_err++; $display("FAIL glitch_t6_state: got %0d expected %0d (t=%0d)", dbg_state, ST_START, cyc - c0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL glitch_t8_state: got %0d expected %0d (t=%0d)", dbg_state, ST_IDLE, cyc - c0); end
    @(posedge clk);
    #1;
    idle(20);
    n_vec++; if (dv_t_q.size() + pe_t_q.size() + se_t_q.size() !== 0) begin n_err++; $display("FAIL glitch_pulses: got %0d expected 0", dv_t_q.size() + pe_t_q.size() + se_t_q.size()); end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c0);
    idle(4);
    n_vec++; if (dv_t_q.size() !== 1) begin n_err++; $display("FAIL after_glitch_dv_count: got %0d expected 1", dv_t_q.size()); end
    else begin
      n_vec++; if (dv_t_q[0] - c0 !== 80) begin n_err++; $display("FAIL after_glitch_dv_time: got %0d expected 80", dv_t_q[0] - c0); end
    end
    n_vec++; if (P_DATA !== 8'h3C) begin n_err++; $display("FAIL after_glitch_pdata: got %h expected 3c", P_DATA); end
  endtask

  task automatic test_stop_err();
    int c0;
    clear_log();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    idle(12);
    n_vec++; if (se_t_q.size() !== 1) begin n_err++; $display("FAIL stop_se_count: got %0d expected 1", se_t_q.size()); end
    else begin
      n_vec++; if (se_t_q[0] - c0 !== 80) begin n_err++; $display("FAIL stop_se_time: got %0d expected 80", se_t_q[0] - c0); end
    end
    n_vec++; if (dv_t_q.size() + pe_t_q.size() !== 0) begin n_err++; $display("FAIL stop_other: got %0d expected 0", dv_t_q.size() + pe_t_q.size()); end
    n_vec++; if (P_DATA !== 8'h3C) begin n_err++; $display("FAIL stop_pdata_hold: got %h expected 3c", P_DATA); end
    clear_log();
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c0);
    idle(4);
    n_vec++; if (dv_t_q.size() !== 1) begin n_err++; $display("FAIL after_stop_dv_count: got %0d expected 1", dv_t_q.size()); end
    n_vec++; if (P_DATA !== 8'h96) begin n_err++; $display("FAIL after_stop_pdata: got %h expected 96", P_DATA); end
  endtask

  task automatic test_back_to_back();
    int c0a, c0b;
    clear_log();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c0a);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c0b);
    idle(4);
    n_vec++; if (dv_t_q.size() !== 2) begin n_err++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_t_q.size()); end
    else begin
      n_vec++; if (dv_t_q[0] - c0a !== 80) begin n_err++; $display("FAIL b2b_first_time: got %0d expected 80", dv_t_q[0] - c0a); end
      n_vec++; if (dv_d_q[0] !== 8'h01) begin n_err++; $display("FAIL b2b_first_data: got %h expected 01", dv_d_q[0]); end
      n_vec++; if (dv_t_q[1] - c0a !== 160) begin n_err++; $display("FAIL b2b_second_time: got %0d expected 160", dv_t_q[1] - c0a); end
      n_vec++; if (dv_d_q[1] !== 8'hFE) begin n_err++; $display("FAIL b2b_second_data: got %h expected fe", dv_d_q[1]); end
    end
    n_vec++; if (pe_t_q.size() + se_t_q.size() !== 0) begin n_err++; $display("FAIL b2b_err_flags: got %0d expected 0", pe_t_q.size() + se_t_q.size()); end
  endtask

  task automatic test_glitch_data();
    int c0;
    clear_log();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c0);
    idle(4);
    n_vec++; if (dv_t_q.size() !== 1) begin n_err++; $display("FAIL gdata_dv_count: got %0d expected 1", dv_t_q.size()); end
    else begin
      n_vec++; if (dv_t_q[0] - c0 !== 80) begin n_err++; $display("FAIL gdata_dv_time: got %0d expected 80", dv_t_q[0] - c0); end
    end
    n_vec++; if (P_DATA !== 8'hC3) begin n_err++; $display("FAIL gdata_pdata: got %h expected c3", P_DATA); end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    RX_IN = 1'b1;
    repeat (3) @(posedge clk);
    n_vec++; if (dbg_state !== ST_DATA) begin n_err++; $display("FAIL mid_state_before: got %0d expected %0d", dbg_state, ST_DATA); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL mid_rst_pdata: got %h expected 00", P_DATA); end
    n_vec++; if ({Data_Valid, Par_Err, Stop_Err} !== 3'b000) begin n_err++; $display("FAIL mid_rst_flags: got %b expected 000", {Data_Valid, Par_Err, Stop_Err}); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL mid_rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(100);
    n_vec++; if (dv_t_q.size() + pe_t_q.size() + se_t_q.size() !== 0) begin n_err++; $display("FAIL mid_rst_pulses: got %0d expected 0", dv_t_q.size() + pe_t_q.size() + se_t_q.size()); end
    n_vec++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL mid_rst_pdata_after: got %h expected 00", P_DATA); end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity_even();
    test_parity_odd_cfg_hold();
    test_start_glitch();
    test_stop_err();
    test_back_to_back();
    test_glitch_data();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
